ppu_palette_lut: RTL and testbench

Parametrised palette subsystem for the PPU. It holds the palette RAM, which is written and read by the CPU through the $2007 data path, and applies the 2C02 backdrop mirroring rule on every access. It also runs a 2-stage render pipeline: pixel palette index → colour index → 24-bit RGB. Grayscale and colour-emphasis modes are applied inside that pipeline. The block sits between the PPU pixel mux and the video output stage.

---
 rtl/ppu_palette_lut.sv | 99 +++++++++
 tb/tb_ppu_palette_lut.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/ppu_palette_lut.sv
// ppu_palette_lut: palette RAM with backdrop mirroring, CPU port and 2-stage pixel-to-RGB pipeline
module ppu_palette_lut #(
   parameter int ADDR_W    = 5,
   parameter int IDX_W     = 6,
   parameter int COLOR_W   = 8,
   parameter int MIRROR_EN = 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  cpu_addr,
   input  logic [7:0]         cpu_wdata,
   input  logic               cpu_we,
   input  logic               cpu_re,
   output logic [7:0]         cpu_rdata,
   output logic               cpu_rvalid,
   input  logic [ADDR_W-1:0]  pix_idx,
   input  logic               pix_valid,
   input  logic               grayscale,
   input  logic [2:0]         emphasis,
   output logic [COLOR_W-1:0] red,
   output logic [COLOR_W-1:0] green,
   output logic [COLOR_W-1:0] blue,
   output logic               rgb_valid
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam int REP = (COLOR_W + 7) / 8;
   localparam logic [ADDR_W-1:0] TOP = ADDR_W'(1) << (ADDR_W - 1);
   localparam logic [IDX_W-1:0] GRAY_MASK = {2'b11, {(IDX_W-2){1'b0}}};
   localparam logic [23:0] PAL [64] = '{
      24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
      24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
      24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
      24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
      24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
      24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
   };
   function automatic logic [ADDR_W-1:0] eff(input logic [ADDR_W-1:0] a);
      return (MIRROR_EN != 0 && a[1:0] == 2'b00) ? (a & ~TOP) : a;
   endfunction
   // 8-bit table colours are bit-replicated so full scale stays full scale at any COLOR_W
   function automatic logic [COLOR_W-1:0] scale(input logic [7:0] c);
      logic [8*REP-1:0] w;
      w = {REP{c}};
      return w[8*REP-1 -: COLOR_W];
   endfunction
   function automatic logic [COLOR_W-1:0] att(input logic [COLOR_W-1:0] c, input logic dim);
      return dim ? c - (c >> 2) : c;
   endfunction
   logic [IDX_W-1:0]   ram [DEPTH];
   logic [IDX_W-1:0]   idx1;
   logic [2:0]         emph1;
   logic               v1;
   logic [ADDR_W-1:0]  cpu_eff, pix_eff;
   logic [23:0]        rom;
   logic               emph_on;
   logic               unused_wdata;
   assign unused_wdata = ^cpu_wdata;
   assign cpu_eff = eff(cpu_addr);
   assign pix_eff = eff(pix_idx);
   assign rom = PAL[6'(idx1)];
   assign emph_on = emph1 != 3'b000;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) ram[i] <= '0;
      end else if (cpu_we) begin
         ram[cpu_eff] <= cpu_wdata[IDX_W-1:0];
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cpu_rdata  <= '0;
         cpu_rvalid <= 1'b0;
      end else begin
         cpu_rvalid <= cpu_re;
         if (cpu_re) cpu_rdata <= 8'(ram[cpu_eff]);
      end
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx1      <= '0;
         emph1     <= '0;
         v1        <= 1'b0;
         red       <= '0;
         green     <= '0;
         blue      <= '0;
         rgb_valid <= 1'b0;
      end else begin
         idx1      <= grayscale ? (ram[pix_eff] & GRAY_MASK) : ram[pix_eff];
         emph1     <= emphasis;
         v1        <= pix_valid;
         red       <= att(scale(rom[23:16]), emph_on && !emph1[0]);
         green     <= att(scale(rom[15:8]),  emph_on && !emph1[1]);
         blue      <= att(scale(rom[7:0]),   emph_on && !emph1[2]);
         rgb_valid <= v1;
      end
   end
endmodule

// File: tb/tb_ppu_palette_lut.sv
// tb_ppu_palette_lut: scoreboard bench for mirrored and flat palette instances
module tb_ppu_palette_lut;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;
   logic [4:0] cpu_addr = '0, pix_idx = '0;
   logic [7:0] cpu_wdata = '0;
   logic       cpu_we = 1'b0, cpu_re = 1'b0, pix_valid = 1'b0, grayscale = 1'b0;
   logic [2:0] emphasis = '0;
   logic [7:0] rd [2];
   logic       rv [2];
   logic [7:0] r [2], g [2], b [2];
   logic       vv [2];
   ppu_palette_lut #(.MIRROR_EN(1)) u0 (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
      .cpu_re(cpu_re), .cpu_rdata(rd[0]), .cpu_rvalid(rv[0]), .pix_idx(pix_idx),
      .pix_valid(pix_valid), .grayscale(grayscale), .emphasis(emphasis),
      .red(r[0]), .green(g[0]), .blue(b[0]), .rgb_valid(vv[0]));
   ppu_palette_lut #(.MIRROR_EN(0)) u1 (
      .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we),
      .cpu_re(cpu_re), .cpu_rdata(rd[1]), .cpu_rvalid(rv[1]), .pix_idx(pix_idx),
      .pix_valid(pix_valid), .grayscale(grayscale), .emphasis(emphasis),
      .red(r[1]), .green(g[1]), .blue(b[1]), .rgb_valid(vv[1]));
   // Reference copy of the 2C02 palette data
   localparam logic [23:0] PAL [64] = '{
      24'h666666, 24'h002A88, 24'h1412A7, 24'h3B00A4, 24'h5C007E, 24'h6E0040, 24'h6C0600, 24'h561D00,
      24'h333500, 24'h0B4800, 24'h005200, 24'h004F08, 24'h00404D, 24'h000000, 24'h000000, 24'h000000,
      24'hADADAD, 24'h155FD9, 24'h4240FF, 24'h7527FE, 24'hA01ACC, 24'hB71E7B, 24'hB53120, 24'h994E00,
      24'h6B6D00, 24'h388700, 24'h0C9300, 24'h008F32, 24'h007C8D, 24'h000000, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'h64B0FF, 24'h9290FF, 24'hC676FF, 24'hF36AFF, 24'hFE6ECC, 24'hFE8170, 24'hEA9E22,
      24'hBCBE00, 24'h88D800, 24'h5CE430, 24'h45E082, 24'h48CDDE, 24'h4F4F4F, 24'h000000, 24'h000000,
      24'hFFFFFF, 24'hC0DFFF, 24'hD3D2FF, 24'hE8C8FF, 24'hFBC2FF, 24'hFEC4EA, 24'hFECCC5, 24'hF7D8A5,
      24'hE4E594, 24'hCFEF96, 24'hBDF4AB, 24'hB3F3CC, 24'hB5EBF2, 24'hB8B8B8, 24'h000000, 24'h000000
   };
   typedef struct packed {int due; int val;} exp_t;
   exp_t cq0[$], cq1[$], pq0[$], pq1[$];
   int mram [2][32];
   int checks = 0, errors = 0, cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;
   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask
   // instance 0 folds 0x10/0x14/0x18/0x1C onto 0x00/0x04/0x08/0x0C; instance 1 is flat
   function automatic int eff(input int m, input int a);
      return (m == 0 && a % 4 == 0) ? a % 16 : a;
   endfunction
   function automatic int colour(input int idx, input bit gs, input int em);
      int i = gs ? (idx & 'h30) : idx;
      int c = int'(PAL[i]);
      int ch [3];
      for (int k = 0; k < 3; k++) begin
         ch[k] = (c >> (16 - 8 * k)) & 255;
         if (em != 0 && ((em >> k) & 1) == 0) ch[k] = ch[k] - ch[k] / 4;
      end
      return (ch[0] << 16) | (ch[1] << 8) | ch[2];
   endfunction
   task automatic step(input bit we, input bit re, input int ca, input int wd,
                       input bit pv, input int pi, input bit gs, input int em);
      cpu_we = we; cpu_re = re; cpu_addr = 5'(ca); cpu_wdata = 8'(wd);
      pix_valid = pv; pix_idx = 5'(pi); grayscale = gs; emphasis = 3'(em);
      for (int m = 0; m < 2; m++) begin
         exp_t e;
         if (re) begin
            e.due = cyc + 1; e.val = mram[m][eff(m, ca)];
            if (m == 0) cq0.push_back(e); else cq1.push_back(e);
         end
         if (pv) begin
            e.due = cyc + 2; e.val = colour(mram[m][eff(m, pi)], gs, em);
            if (m == 0) pq0.push_back(e); else pq1.push_back(e);
         end
      end
      if (we) for (int m = 0; m < 2; m++) mram[m][eff(m, ca)] = wd % 64;
      @(posedge clk); #1;
   endtask
   task automatic wr(input int a, input int d); step(1, 0, a, d, 0, 0, 0, 0); endtask
   task automatic rdc(input int a); step(0, 1, a, 0, 0, 0, 0, 0); endtask
   task automatic pix(input int i, input bit gs, input int em); step(0, 0, 0, 0, 1, i, gs, em); endtask
   task automatic idle(); step(0, 0, 0, 0, 0, 0, 0, 0); endtask
   always @(negedge clk) begin
      if (!rst) begin
         exp_t e;
         if (cq0.size() > 0 && cq0[0].due <= cyc) begin
            e = cq0.pop_front(); chk("cpu_rd_m", {rv[0], rd[0]}, {1'b1, e.val[7:0]});
         end else if (rv[0]) chk("cpu_rd_m_spurious", 32'(rv[0]), 0);
         if (cq1.size() > 0 && cq1[0].due <= cyc) begin
            e = cq1.pop_front(); chk("cpu_rd_f", {rv[1], rd[1]}, {1'b1, e.val[7:0]});
         end else if (rv[1]) chk("cpu_rd_f_spurious", 32'(rv[1]), 0);
         if (pq0.size() > 0 && pq0[0].due <= cyc) begin
            e = pq0.pop_front(); chk("pix_m", {vv[0], r[0], g[0], b[0]}, {1'b1, e.val[23:0]});
         end else if (vv[0]) chk("pix_m_spurious", 32'(vv[0]), 0);
         if (pq1.size() > 0 && pq1[0].due <= cyc) begin
            e = pq1.pop_front(); chk("pix_f", {vv[1], r[1], g[1], b[1]}, {1'b1, e.val[23:0]});
         end else if (vv[1]) chk("pix_f_spurious", 32'(vv[1]), 0);
      end
   end
   task automatic chk_zero(input string name);
      for (int m = 0; m < 2; m++)
         chk(name, {rd[m], rv[m], r[m], g[m], b[m], vv[m]}, 0);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_zero("reset_outputs");
      rst = 1'b0;
      wr(3, 'h16); rdc(3);
      chk("wr_rd_03", {rv[0], rd[0]}, {1'b1, 8'h16});
      wr(5, 'hFF); rdc(5);
      chk("wr_rd_trunc", rd[0], 'h3F);
      wr('h10, 'h30); rdc(0);
      chk("mirror_10_00", rd[0], 'h30);
      chk("flat_00", rd[1], 'h00);
      wr(4, 'h0F); rdc('h14);
      chk("mirror_04_14", rd[0], 'h0F);
      chk("flat_14", rd[1], 'h00);
      wr(1, 'h0F); wr(2, 'h20);
      pix(1, 0, 0); pix(2, 0, 0);
      chk("pix_black", {vv[0], r[0], g[0], b[0]}, {1'b1, 24'h000000});
      idle();
      chk("pix_white", {vv[0], r[0], g[0], b[0]}, {1'b1, 24'hFFFFFF});
      wr(2, 'h2F); pix(2, 1, 0); idle();
      chk("grayscale", {r[0], g[0], b[0]}, 24'hFFFFFF);
      wr(2, 'h20); pix(2, 0, 1); idle();
      chk("emph_r", {r[0], g[0], b[0]}, 24'hFFC0C0);
      pix(2, 0, 7); idle();
      chk("emph_all", {r[0], g[0], b[0]}, 24'hFFFFFF);
      wr(7, 'h20);
      step(1, 1, 7, 'h11, 1, 7, 0, 0);
      chk("collide_rd", rd[0], 'h20);
      idle();
      chk("collide_pix", {r[0], g[0], b[0]}, 24'hFFFFFF);
      rdc(7);
      chk("after_collide", rd[0], 'h11);
      idle();
      chk("rdata_hold", {rv[0], rd[0]}, {1'b0, 8'h11});
      for (int n = 0; n < 400; n++)
         step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 255),
              $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 3) == 0, $urandom_range(0, 7));
      for (int n = 0; n < 3; n++) pix($urandom_range(0, 31), 0, 0);
      rst = 1'b1;
      #1;
      chk_zero("async_reset");
      cq0.delete(); cq1.delete(); pq0.delete(); pq1.delete();
      for (int m = 0; m < 2; m++) for (int a = 0; a < 32; a++) mram[m][a] = 0;
      @(posedge clk); #1;
      pix_valid = 1'b0;
      rst = 1'b0;
      idle();
      chk("no_valid_after_rst1", vv[0], 0);
      idle();
      chk("no_valid_after_rst2", vv[0], 0);
      rdc('h13);
      chk("ram_cleared", {rv[0], rd[0]}, {1'b1, 8'h00});
      for (int n = 0; n < 100; n++)
         step($urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 31), $urandom_range(0, 255),
              $urandom_range(0, 1) == 1, $urandom_range(0, 31), $urandom_range(0, 1) == 1, $urandom_range(0, 7));
      repeat (4) idle();
      chk("queues_drained", cq0.size() + cq1.size() + pq0.size() + pq1.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
